// File: rtl/irq_timer_ctrl.sv
// Memory-mapped interrupt source: 64-bit prescaled free-running counter with an
// armed compare (timer interrupt) plus an N-line edge-latched external interrupt unit.
module irq_timer_ctrl #(
    parameter logic [15:0] IO_BASE = 16'hC000,
    parameter int          N_IRQ   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [13:0]      io_wadr,
    input  logic             io_we,
    input  logic [31:0]      io_wdata,
    input  logic [13:0]      io_radr,
    input  logic             io_re,
    output logic [31:0]      io_rdata,
    input  logic [N_IRQ-1:0] ext_irq,
    input  logic             csr_meie,
    input  logic             csr_mtie,
    output logic             g_interrupt,
    output logic             g_interrupt_1shot,
    output logic [1:0]       g_interrupt_priv,
    output logic             frc_cntr_val_leq
);

    localparam logic [2:0] OFF_FRC_LO = 3'd0;
    localparam logic [2:0] OFF_FRC_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO = 3'd2;
    localparam logic [2:0] OFF_CMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_PEND   = 3'd5;
    localparam logic [2:0] OFF_MASK   = 3'd6;

    logic [63:0]      frc;
    logic [63:0]      cmp;
    logic             cmp_arm;
    logic             ctrl_en;
    logic [7:0]       ctrl_psc;
    logic [7:0]       psc_cnt;
    logic [31:0]      hi_shadow;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] sync1, sync2, sync3;
    logic [N_IRQ-1:0] edge_det;
    logic [N_IRQ-1:0] pend_w1c;
    logic             g_int_dly;
    logic [31:0]      rd_val;

    logic w_hit, r_hit, tick;
    logic wr_frc_lo, wr_frc_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_pend, wr_mask;

    assign w_hit = io_we && (io_wadr[13:3] == IO_BASE[15:5]);
    assign r_hit = io_re && (io_radr[13:3] == IO_BASE[15:5]);

    assign wr_frc_lo = w_hit && (io_wadr[2:0] == OFF_FRC_LO);
    assign wr_frc_hi = w_hit && (io_wadr[2:0] == OFF_FRC_HI);
    assign wr_cmp_lo = w_hit && (io_wadr[2:0] == OFF_CMP_LO);
    assign wr_cmp_hi = w_hit && (io_wadr[2:0] == OFF_CMP_HI);
    assign wr_ctrl   = w_hit && (io_wadr[2:0] == OFF_CTRL);
    assign wr_pend   = w_hit && (io_wadr[2:0] == OFF_PEND);
    assign wr_mask   = w_hit && (io_wadr[2:0] == OFF_MASK);

    assign tick = ctrl_en && (psc_cnt == ctrl_psc);

    // A software write to either FRC half wins over a same-cycle increment and restarts the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frc     <= '0;
            psc_cnt <= '0;
        end else if (wr_frc_lo || wr_frc_hi) begin
            psc_cnt <= '0;
            if (wr_frc_lo) frc[31:0]  <= io_wdata;
            if (wr_frc_hi) frc[63:32] <= io_wdata;
        end else if (!ctrl_en) begin
            psc_cnt <= '0;
        end else if (tick) begin
            psc_cnt <= '0;
            frc     <= frc + 64'd1;
        end else begin
            psc_cnt <= psc_cnt + 8'd1;
        end
    end

    // Arm only after the high half lands so a half-updated compare value cannot match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp      <= '1;
            cmp_arm  <= 1'b0;
            ctrl_en  <= 1'b0;
            ctrl_psc <= '0;
            mask     <= '0;
        end else begin
            if (wr_cmp_lo) begin
                cmp[31:0] <= io_wdata;
                cmp_arm   <= 1'b0;
            end
            if (wr_cmp_hi) begin
                cmp[63:32] <= io_wdata;
                cmp_arm    <= 1'b1;
            end
            if (wr_ctrl) begin
                ctrl_en  <= io_wdata[0];
                ctrl_psc <= io_wdata[15:8];
            end
            if (wr_mask) mask <= io_wdata[N_IRQ-1:0];
        end
    end

    assign edge_det = sync2 & ~sync3;
    assign pend_w1c = wr_pend ? io_wdata[N_IRQ-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            sync3     <= '0;
            pend      <= '0;
            g_int_dly <= 1'b0;
        end else begin
            sync1     <= ext_irq;
            sync2     <= sync1;
            sync3     <= sync2;
            pend      <= (pend & ~pend_w1c) | edge_det;
            g_int_dly <= g_interrupt;
        end
    end

    always_comb begin
        rd_val = '0;
        case (io_radr[2:0])
            OFF_FRC_LO: rd_val = frc[31:0];
            OFF_FRC_HI: rd_val = hi_shadow;
            OFF_CMP_LO: rd_val = cmp[31:0];
            OFF_CMP_HI: rd_val = cmp[63:32];
            OFF_CTRL:   rd_val = {16'b0, ctrl_psc, 7'b0, ctrl_en};
            OFF_PEND:   rd_val = 32'(pend);
            OFF_MASK:   rd_val = 32'(mask);
            default:    rd_val = '0;
        endcase
    end

    // Reading FRC_LO snapshots the live high half so a later FRC_HI read is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdata  <= '0;
            hi_shadow <= '0;
        end else if (io_re) begin
            io_rdata <= r_hit ? rd_val : 32'd0;
            if (r_hit && (io_radr[2:0] == OFF_FRC_LO)) hi_shadow <= frc[63:32];
        end
    end

    assign g_interrupt       = csr_meie & (|(pend & mask));
    assign g_interrupt_1shot = g_interrupt & ~g_int_dly;
    assign g_interrupt_priv  = 2'b11;
    assign frc_cntr_val_leq  = csr_mtie & cmp_arm & (cmp <= frc);

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl: register table plus hand-timed counter,
// compare, interrupt and reset sequences. Inputs change and outputs are sampled on negedges.
module tb_irq_timer_ctrl;

    localparam int N_IRQ = 4;

    localparam logic [13:0] A_FRC_LO = 14'h3000;
    localparam logic [13:0] A_FRC_HI = 14'h3001;
    localparam logic [13:0] A_CMP_LO = 14'h3002;
    localparam logic [13:0] A_CMP_HI = 14'h3003;
    localparam logic [13:0] A_CTRL   = 14'h3004;
    localparam logic [13:0] A_PEND   = 14'h3005;
    localparam logic [13:0] A_MASK   = 14'h3006;
    localparam logic [13:0] A_RSVD   = 14'h3007;
    localparam logic [13:0] A_MISS   = 14'h2006;

    logic             clk;
    logic             rst_n;
    logic [13:0]      io_wadr;
    logic             io_we;
    logic [31:0]      io_wdata;
    logic [13:0]      io_radr;
    logic             io_re;
    logic [31:0]      io_rdata;
    logic [N_IRQ-1:0] ext_irq;
    logic             csr_meie;
    logic             csr_mtie;
    logic             g_interrupt;
    logic             g_interrupt_1shot;
    logic [1:0]       g_interrupt_priv;
    logic             frc_cntr_val_leq;

    int checks;
    int errors;
    logic [31:0] exp_q[$];
    logic [31:0] rd;

    typedef struct packed {
        logic        we;
        logic [13:0] wadr;
        logic [31:0] wdata;
        logic [13:0] radr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    irq_timer_ctrl #(.IO_BASE(16'hC000), .N_IRQ(N_IRQ)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .io_wadr           (io_wadr),
        .io_we             (io_we),
        .io_wdata          (io_wdata),
        .io_radr           (io_radr),
        .io_re             (io_re),
        .io_rdata          (io_rdata),
        .ext_irq           (ext_irq),
        .csr_meie          (csr_meie),
        .csr_mtie          (csr_mtie),
        .g_interrupt       (g_interrupt),
        .g_interrupt_1shot (g_interrupt_1shot),
        .g_interrupt_priv  (g_interrupt_priv),
        .frc_cntr_val_leq  (frc_cntr_val_leq)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n    = 1'b0;
        io_we    = 1'b0;
        io_re    = 1'b0;
        io_wadr  = '0;
        io_radr  = '0;
        io_wdata = '0;
        ext_irq  = '0;
        csr_meie = 1'b0;
        csr_mtie = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Driver tasks: called on a negedge, the access lands on the next posedge.
    task automatic io_write(input logic [13:0] adr, input logic [31:0] data);
        io_wadr  = adr;
        io_wdata = data;
        io_we    = 1'b1;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic io_read(input logic [13:0] adr, output logic [31:0] data);
        io_radr = adr;
        io_re   = 1'b1;
        @(negedge clk);
        io_re = 1'b0;
        data  = io_rdata;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b0, 14'h0,    32'h0,          A_FRC_LO, 32'h0000_0000};
        vecs[1]  = '{1'b0, 14'h0,    32'h0,          A_FRC_HI, 32'h0000_0000};
        vecs[2]  = '{1'b0, 14'h0,    32'h0,          A_CMP_LO, 32'hFFFF_FFFF};
        vecs[3]  = '{1'b0, 14'h0,    32'h0,          A_CMP_HI, 32'hFFFF_FFFF};
        vecs[4]  = '{1'b0, 14'h0,    32'h0,          A_CTRL,   32'h0000_0000};
        vecs[5]  = '{1'b0, 14'h0,    32'h0,          A_PEND,   32'h0000_0000};
        vecs[6]  = '{1'b0, 14'h0,    32'h0,          A_MASK,   32'h0000_0000};
        vecs[7]  = '{1'b1, A_MASK,   32'hFFFF_FFFF,  A_MASK,   32'h0000_000F};
        vecs[8]  = '{1'b1, A_MISS,   32'h0000_0000,  A_MASK,   32'h0000_000F};
        vecs[9]  = '{1'b0, 14'h0,    32'h0,          A_MISS,   32'h0000_0000};
        vecs[10] = '{1'b1, A_CTRL,   32'hFFFF_FFFE,  A_CTRL,   32'h0000_FF00};
        vecs[11] = '{1'b1, A_CMP_LO, 32'h1234_5678,  A_CMP_LO, 32'h1234_5678};
        vecs[12] = '{1'b1, A_CMP_HI, 32'h9ABC_DEF0,  A_CMP_HI, 32'h9ABC_DEF0};
        vecs[13] = '{1'b1, A_RSVD,   32'hDEAD_BEEF,  A_RSVD,   32'h0000_0000};
        vecs[14] = '{1'b1, A_PEND,   32'h0000_000F,  A_PEND,   32'h0000_0000};
        vecs[15] = '{1'b1, A_MASK,   32'h0000_000A,  A_MASK,   32'h0000_000A};
        vecs[16] = '{1'b1, A_CTRL,   32'h0000_0000,  A_CTRL,   32'h0000_0000};
        vecs[17] = '{1'b0, 14'h0,    32'h0,          A_FRC_LO, 32'h0000_0000};

        // Reset state and register table
        do_reset();
        check("rst_rdata", io_rdata, 32'h0);
        check("rst_gint", g_interrupt, 1'b0);
        check("rst_1shot", g_interrupt_1shot, 1'b0);
        check("rst_priv", g_interrupt_priv, 2'b11);
        check("rst_leq", frc_cntr_val_leq, 1'b0);
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].we) io_write(vecs[i].wadr, vecs[i].wdata);
            io_read(vecs[i].radr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // PSC=0: one increment per cycle
        do_reset();
        io_write(A_CTRL, 32'h0000_0001);
        repeat (10) @(negedge clk);
        io_read(A_FRC_LO, rd);
        check("frc_lo_10", rd, 32'd10);
        repeat (3) @(negedge clk);
        check("rdata_hold", io_rdata, 32'd10);
        io_read(A_FRC_HI, rd);
        check("frc_hi_0", rd, 32'd0);

        // PSC=3: back-to-back reads see one step every 4 cycles, then disable freezes it
        do_reset();
        io_write(A_CTRL, 32'h0000_0301);
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i / 4));
        for (int i = 0; i < 10; i++) begin
            io_read(A_FRC_LO, rd);
            check($sformatf("psc3_rd%0d", i), rd, exp_q.pop_front());
        end
        io_write(A_CTRL, 32'h0);
        repeat (10) @(negedge clk);
        io_read(A_FRC_LO, rd);
        check("frc_hold", rd, 32'd2);

        // Wrap and coherent high-half snapshot
        do_reset();
        io_write(A_FRC_LO, 32'hFFFF_FFFE);
        io_write(A_FRC_HI, 32'hFFFF_FFFF);
        io_write(A_CTRL, 32'h0000_0001);
        @(negedge clk);
        io_read(A_FRC_LO, rd);
        check("wrap_lo_pre", rd, 32'hFFFF_FFFF);
        io_read(A_FRC_HI, rd);
        check("wrap_hi_shadow", rd, 32'hFFFF_FFFF);
        io_read(A_FRC_LO, rd);
        check("wrap_lo_post", rd, 32'd1);
        io_read(A_FRC_HI, rd);
        check("wrap_hi_post", rd, 32'd0);

        // Compare arming and timer interrupt
        do_reset();
        csr_mtie = 1'b1;
        io_write(A_FRC_LO, 32'h10);
        io_write(A_CMP_HI, 32'h0);
        check("cmp_above", frc_cntr_val_leq, 1'b0);
        io_write(A_CMP_LO, 32'h5);
        check("cmp_disarmed", frc_cntr_val_leq, 1'b0);
        io_write(A_CMP_HI, 32'h0);
        check("cmp_armed_below", frc_cntr_val_leq, 1'b1);
        io_write(A_CMP_LO, 32'h20);
        check("cmp_lo_clears", frc_cntr_val_leq, 1'b0);
        io_write(A_CMP_HI, 32'h0);
        check("cmp_0x20_armed", frc_cntr_val_leq, 1'b0);
        io_write(A_CTRL, 32'h0000_0001);
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            check($sformatf("leq_frc_%0h", 16 + j), frc_cntr_val_leq, (16 + j) >= 32);
        end
        csr_mtie = 1'b0;
        #1;
        check("leq_mtie_off", frc_cntr_val_leq, 1'b0);
        csr_mtie = 1'b1;
        #1;
        check("leq_mtie_on", frc_cntr_val_leq, 1'b1);
        @(negedge clk);

        // External interrupt latency, one-shot and W1C
        do_reset();
        csr_meie = 1'b1;
        io_write(A_MASK, 32'h5);
        ext_irq[2] = 1'b1;
        @(negedge clk);
        check("irq2_c1", g_interrupt, 1'b0);
        @(negedge clk);
        ext_irq[2] = 1'b0;
        check("irq2_c2", g_interrupt, 1'b0);
        @(negedge clk);
        check("irq2_c3_gint", g_interrupt, 1'b1);
        check("irq2_c3_1shot", g_interrupt_1shot, 1'b1);
        @(negedge clk);
        check("irq2_c4_gint", g_interrupt, 1'b1);
        check("irq2_c4_1shot", g_interrupt_1shot, 1'b0);
        io_read(A_PEND, rd);
        check("irq2_pend", rd, 32'h4);
        io_write(A_PEND, 32'h4);
        check("irq2_w1c_gint", g_interrupt, 1'b0);

        // Masked line still latches
        ext_irq[1] = 1'b1;
        repeat (2) @(negedge clk);
        ext_irq[1] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("irq1_masked_%0d", j), g_interrupt, 1'b0);
        end
        io_read(A_PEND, rd);
        check("irq1_pend", rd, 32'h2);
        io_write(A_PEND, 32'h2);

        // Edge and W1C on the same bit in the same cycle: set wins
        ext_irq[0] = 1'b1;
        repeat (2) @(negedge clk);
        io_write(A_PEND, 32'h1);
        ext_irq[0] = 1'b0;
        io_read(A_PEND, rd);
        check("irq0_set_wins", rd, 32'h1);
        check("irq0_gint", g_interrupt, 1'b1);

        // Asynchronous reset mid-operation
        csr_mtie = 1'b1;
        io_write(A_CMP_LO, 32'h0);
        io_write(A_CMP_HI, 32'h0);
        io_write(A_CTRL, 32'h0000_0001);
        repeat (3) @(negedge clk);
        io_read(A_PEND, rd);
        check("pre_rst_rdata", io_rdata, 32'h1);
        check("pre_rst_leq", frc_cntr_val_leq, 1'b1);
        ext_irq[3] = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_gint", g_interrupt, 1'b0);
        check("arst_1shot", g_interrupt_1shot, 1'b0);
        check("arst_leq", frc_cntr_val_leq, 1'b0);
        check("arst_rdata", io_rdata, 32'h0);
        ext_irq = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        io_read(A_PEND, rd);
        check("post_rst_pend", rd, 32'h0);
        io_read(A_FRC_LO, rd);
        check("post_rst_frc_lo", rd, 32'h0);
        check("post_rst_leq", frc_cntr_val_leq, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
